// File: rtl/floo_inject_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// floo_inject_wrr_arbiter
//   Weighted round-robin arbiter that shares one NI injection port among
//   NumReq tile-local requesters. A grant is held for a whole packet, up to and
//   including the flit marked last, so flits from different requesters never
//   interleave. The data path from requester to output is combinational.
//
//   Each requester receives w packets per turn. w comes from weight_i, and a
//   weight of 0 counts as 1. The weight is sampled only when a turn starts.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   weight_i     per-requester packets-per-turn, packed NumReq x WeightWidth
//   req_valid_i  per-requester flit valid
//   req_last_i   per-requester last-flit marker
//   req_data_i   per-requester payload, packed NumReq x DataWidth
//   req_ready_o  per-requester accept (only the granted requester)
//   out_valid_o  flit valid toward NI
//   out_last_o   last flit of packet toward NI
//   out_data_o   payload of the granted requester
//   out_src_o    index of the granted requester
//   out_ready_i  NI accepts flit
//   busy_o       grant locked on a packet in progress
// -----------------------------------------------------------------------------
module floo_inject_wrr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned WeightWidth = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq*WeightWidth-1:0] weight_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_last_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          out_valid_o,
  output logic                          out_last_o,
  output logic [DataWidth-1:0]          out_data_o,
  output logic [$clog2(NumReq)-1:0]     out_src_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e                 r_state;
  logic [IdxW-1:0]        r_owner;
  logic [IdxW-1:0]        r_ptr;
  logic [WeightWidth-1:0] r_credit;

  logic                   w_locked;
  logic                   w_any;
  logic [IdxW-1:0]        w_idle_idx;
  logic [IdxW-1:0]        w_gidx;
  logic                   w_granted;
  logic                   w_valid;
  logic                   w_done;
  logic [WeightWidth-1:0] w_weight;
  logic [WeightWidth-1:0] w_wo;
  logic [WeightWidth-1:0] w_eff;

  // (base + off) mod NumReq, where base < NumReq and off < NumReq.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return s[IdxW-1:0];
  endfunction

  // The IDLE grant is the first valid requester found by searching round-robin
  // from r_ptr.
  always_comb begin
    w_any      = 1'b0;
    w_idle_idx = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_any && req_valid_i[wrap_add(r_ptr, i)]) begin
        w_any      = 1'b1;
        w_idle_idx = wrap_add(r_ptr, i);
      end
    end
  end

  assign w_locked  = (r_state == LOCKED);
  assign w_gidx    = w_locked ? r_owner : w_idle_idx;
  assign w_granted = w_locked | w_any;
  assign w_valid   = w_locked ? req_valid_i[r_owner] : w_any;

  always_comb begin
    out_valid_o = w_valid;
    out_src_o   = '0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    req_ready_o = '0;
    if (w_granted) begin
      out_src_o           = w_gidx;
      out_last_o          = req_last_i[w_gidx];
      out_data_o          = req_data_i[32'(w_gidx)*DataWidth +: DataWidth];
      req_ready_o[w_gidx] = out_ready_i;
    end
  end

  assign w_done = w_valid & out_ready_i & out_last_o;

  // A turn continues only when the finishing owner already holds the pointer
  // and has credit left. In every other case the weight is sampled again.
  assign w_weight = weight_i[32'(w_gidx)*WeightWidth +: WeightWidth];
  assign w_wo     = (w_weight == '0) ? WeightWidth'(1) : w_weight;
  assign w_eff    = ((w_gidx == r_ptr) && (r_credit != '0)) ? r_credit : w_wo;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_credit <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid && !w_done) begin
            r_state <= LOCKED;
            r_owner <= w_gidx;
          end
        end
        LOCKED: begin
          if (w_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_done) begin
        if (w_eff <= WeightWidth'(1)) begin
          r_ptr    <= wrap_add(w_gidx, 1);
          r_credit <= '0;
        end else begin
          r_ptr    <= w_gidx;
          r_credit <= w_eff - WeightWidth'(1);
        end
      end
    end
  end

  assign busy_o = w_locked;

endmodule
